hazard_unit: RTL



---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hz_fwd_match.sv | 50 +++++
 rtl/hazard_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and helpers for the pipeline interlock and
//                bypass controller (scoreboard entry type, select width).
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Widest register address a scoreboard entry can hold.
  localparam int HZ_AW_MAX = 4;

  // Forwarding select value meaning "take the regfile read data".
  localparam int FWD_RF = 0;

  // One tracked in-flight instruction.
  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [HZ_AW_MAX-1:0] addr;
    logic                 is_load;
  } hz_entry_t;

  // Bits needed to encode "regfile" plus one code per tracked stage.
  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hz_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : hz_fwd_match
//  Description : Bypass selection for one register read port. Finds the
//                youngest tracked stage writing the requested register,
//                muxes its result in place of the regfile data and flags a
//                load whose data is not yet available.
//  Revision    : 1.0 - initial release
// ============================================================================
module hz_fwd_match
  import hazard_pkg::*;
#(
  parameter int NSTAGES    = 3,
  parameter int AW         = 4,
  parameter int DW         = 16,
  parameter int LOAD_STAGE = 2,
  parameter int SW         = 2
) (
  input  hz_entry_t [NSTAGES-1:0] entries,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  input  logic [DW-1:0]           rf_data,
  input  logic [NSTAGES*DW-1:0]   stage_data,
  output logic [SW-1:0]           fwd_sel,
  output logic [DW-1:0]           rd_data,
  output logic                    load_hazard
);

  logic [HZ_AW_MAX-1:0] addr_ext;

  // Entries store addresses zero-extended to the package width.
  assign addr_ext = HZ_AW_MAX'(rd_addr);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_sel     = SW'(FWD_RF);
    rd_data     = rf_data;
    load_hazard = 1'b0;
    for (int s = NSTAGES - 1; s >= 0; s--) begin
      if (rd_en && entries[s].valid && entries[s].wr_en &&
          (entries[s].addr == addr_ext)) begin
        fwd_sel     = SW'(s + 1);
        rd_data     = stage_data[s*DW +: DW];
        load_hazard = entries[s].is_load && (s < LOAD_STAGE);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline interlock and bypass controller. Tracks register
//                writes in flight in the post-decode stages, drives operand
//                forwarding, raises load-use stalls and squashes decode for a
//                window after a taken branch flush.
//                Optional build macro HAZARD_PERF_EN adds saturating 32-bit
//                stall and flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int AW          = 4,
  parameter int DW          = 16,
  parameter int NRD         = 2,
  parameter int NSTAGES     = 3,
  parameter int LOAD_STAGE  = 2,
  parameter int KILL_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dec_valid,
  input  logic [NRD-1:0]                   dec_rd_en,
  input  logic [NRD*AW-1:0]                dec_rd_addr,
  input  logic                             dec_wr_en,
  input  logic [AW-1:0]                    dec_wr_addr,
  input  logic                             dec_is_load,
  input  logic [NRD*DW-1:0]                rf_rd_data,
  input  logic [NSTAGES*DW-1:0]            stage_data,
  input  logic                             flush_req,
  output logic                             stall,
  output logic                             dec_kill,
  output logic [NRD*sel_width(NSTAGES)-1:0] fwd_sel,
  output logic [NRD*DW-1:0]                rd_data,
  output logic [NSTAGES-1:0]               stage_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cnt,
  output logic [31:0]                      perf_flush_cnt
`endif
);

  localparam int SW = sel_width(NSTAGES);
  localparam int KW = $clog2(KILL_CYCLES + 1);
  localparam logic [KW-1:0] KILL_RELOAD = KW'(KILL_CYCLES - 1);

  hz_entry_t [NSTAGES-1:0] entries_q, entries_d;
  logic [KW-1:0]           kill_cnt_q, kill_cnt_d;
  logic [NRD-1:0]          load_haz;
  logic                    eff;

  // A flush kills the current slot; a nonzero counter kills the ones after.
  assign dec_kill = flush_req | (kill_cnt_q != '0);
  assign eff      = dec_valid & ~dec_kill;
  assign stall    = eff & (|load_haz);

  // One bypass matcher per read port.
  generate
    for (genvar i = 0; i < NRD; i++) begin : g_port
      hz_fwd_match #(
        .NSTAGES    (NSTAGES),
        .AW         (AW),
        .DW         (DW),
        .LOAD_STAGE (LOAD_STAGE),
        .SW         (SW)
      ) u_match (
        .entries     (entries_q),
        .rd_en       (dec_rd_en[i]),
        .rd_addr     (dec_rd_addr[i*AW +: AW]),
        .rf_data     (rf_rd_data[i*DW +: DW]),
        .stage_data  (stage_data),
        .fwd_sel     (fwd_sel[i*SW +: SW]),
        .rd_data     (rd_data[i*DW +: DW]),
        .load_hazard (load_haz[i])
      );
    end
  endgenerate

  // Shift the scoreboard down the pipe; EX takes decode only when it issues.
  always_comb begin
    entries_d = '0;
    for (int s = 1; s < NSTAGES; s++) begin
      entries_d[s] = entries_q[s-1];
    end
    if (eff && !stall) begin
      entries_d[0].valid   = 1'b1;
      entries_d[0].wr_en   = dec_wr_en;
      entries_d[0].addr    = HZ_AW_MAX'(dec_wr_addr);
      entries_d[0].is_load = dec_is_load;
    end
  end

  // Kill window: a flush reloads (never accumulates), otherwise count down.
  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (flush_req) begin
      kill_cnt_d = KILL_RELOAD;
    end else if (kill_cnt_q != '0) begin
      kill_cnt_d = kill_cnt_q - KW'(1);
    end
  end

  // Occupancy view of the tracked stages.
  always_comb begin
    stage_valid = '0;
    for (int s = 0; s < NSTAGES; s++) begin
      stage_valid[s] = entries_q[s].valid;
    end
  end

  // Scoreboard and kill counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q  <= '0;
      kill_cnt_q <= '0;
    end else begin
      entries_q  <= entries_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (flush_req && (perf_flush_q != 32'hFFFF_FFFF)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
`default_nettype wire
